alu_seq: RTL and testbench

Byte-serial multi-word arithmetic sequencer that sits directly upstream of the 8-bit `alu`. It accepts a BYTES-wide operation, drives the ALU one byte per cycle (LSB first), and chains carry/borrow through the ALU's ADDC/SUBC modes. It collects the ALU result bytes into a wide result with final carry and zero flags. It lets the 8-bit datapath serve wide counters and checksums elsewhere in the UART design.

---
 rtl/alu_seq.sv | 129 ++++++++++++
 tb/tb_alu_seq.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - byte-serial wide AND/OR/ADD/SUB sequencer driving an 8-bit ALU
// Walks the operands LSB-first through the ALU, chaining carry/borrow via ADDC/SUBC.
module alu_seq #(
  parameter int BYTES = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  input  logic [1:0]           op_i,
  input  logic [8*BYTES-1:0]   a_i,
  input  logic [8*BYTES-1:0]   b_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [8*BYTES-1:0]   result_o,
  output logic                 carry_o,
  output logic                 zero_o,
  output logic [7:0]           alu_a_o,
  output logic [7:0]           alu_b_o,
  output logic [2:0]           alu_cs_o,
  output logic                 alu_cin_o,
  input  logic [7:0]           alu_s_i,
  input  logic                 alu_cout_i
);

  localparam int W  = 8 * BYTES;
  localparam int KW = (BYTES > 1) ? $clog2(BYTES) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [KW-1:0] K_LAST = KW'(BYTES - 1);

  logic [1:0]    state_q, state_d;
  logic [W-1:0]  a_q, a_d, b_q, b_d;
  logic [1:0]    op_q, op_d;
  logic [KW-1:0] k_q, k_d;
  logic          c_q, c_d;
  logic [W-1:0]  result_q, result_d;
  logic          carry_q, carry_d;
  logic          zero_q, zero_d;

  logic          run;
  logic [W-1:0]  a_sh, b_sh;

  assign run  = (state_q == S_RUN);
  assign a_sh = a_q >> {k_q, 3'b000};
  assign b_sh = b_q >> {k_q, 3'b000};

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    op_d     = op_q;
    k_d      = k_q;
    c_d      = c_q;
    result_d = result_q;
    carry_d  = carry_q;
    zero_d   = zero_q;
    if (state_q == S_RUN) begin
      result_d[{k_q, 3'b000} +: 8] = alu_s_i;
      c_d = op_q[1] ? alu_cout_i : 1'b0;
      k_d = k_q + 1'b1;
      if (k_q == K_LAST) begin
        // Flags are taken from the fully assembled value, including the byte captured now.
        state_d = S_DONE;
        k_d     = '0;
        carry_d = c_d;
        zero_d  = (result_d == '0);
      end
    end else if (start_i) begin
      state_d = S_RUN;
      a_d     = a_i;
      b_d     = b_i;
      op_d    = op_i;
      k_d     = '0;
      c_d     = 1'b0;
    end else begin
      state_d = S_IDLE;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= 2'b00;
      k_q      <= '0;
      c_q      <= 1'b0;
      result_q <= '0;
      carry_q  <= 1'b0;
      zero_q   <= 1'b1;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      k_q      <= k_d;
      c_q      <= c_d;
      result_q <= result_d;
      carry_q  <= carry_d;
      zero_q   <= zero_d;
    end
  end

  always_comb begin
    alu_cs_o = 3'b000;
    if (run) begin
      case (op_q)
        2'b00:   alu_cs_o = 3'b000;
        2'b01:   alu_cs_o = 3'b001;
        2'b10:   alu_cs_o = 3'b110;
        default: alu_cs_o = 3'b101;
      endcase
    end
  end

  assign alu_a_o   = run ? a_sh[7:0] : 8'h00;
  assign alu_b_o   = run ? b_sh[7:0] : 8'h00;
  assign alu_cin_o = run & op_q[1] & c_q;

  assign busy_o   = run;
  assign done_o   = (state_q == S_DONE);
  assign result_o = result_q;
  assign carry_o  = carry_q;
  assign zero_o   = zero_q;

endmodule

// File: tb/tb_alu_seq.sv
// tb/tb_alu_seq.sv - randomized and directed self-checking bench for alu_seq
// Wide results come from plain 32-bit arithmetic; the 8-bit ALU is modelled behaviourally.
module tb_alu_seq;
  localparam int BYTES = 4;
  localparam int W     = 8 * BYTES;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [1:0]    op;
  logic [W-1:0]  a, b;
  logic          busy, done;
  logic [W-1:0]  result;
  logic          carry, zero;
  logic [7:0]    alu_a, alu_b, alu_s;
  logic [2:0]    alu_cs;
  logic          alu_cin, alu_cout;
  logic [8:0]    alu_t;

  int tests = 0;
  int fails = 0;
  logic cin_log [0:7];
  int   nbytes;
  int   lat;

  alu_seq #(.BYTES(BYTES)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .op_i(op), .a_i(a), .b_i(b),
    .busy_o(busy), .done_o(done), .result_o(result), .carry_o(carry), .zero_o(zero),
    .alu_a_o(alu_a), .alu_b_o(alu_b), .alu_cs_o(alu_cs), .alu_cin_o(alu_cin),
    .alu_s_i(alu_s), .alu_cout_i(alu_cout)
  );

  always #5 clk = ~clk;

  always_comb begin
    alu_s    = 8'h00;
    alu_cout = 1'b0;
    alu_t    = 9'h000;
    case (alu_cs)
      3'b000: alu_s = alu_a & alu_b;
      3'b001: alu_s = alu_a | alu_b;
      3'b110: begin
        alu_t    = {1'b0, alu_a} + {1'b0, alu_b} + {8'b0, alu_cin};
        alu_s    = alu_t[7:0];
        alu_cout = alu_t[8];
      end
      3'b101: begin
        alu_t    = {1'b0, alu_a} - {1'b0, alu_b} - {8'b0, alu_cin};
        alu_s    = alu_t[7:0];
        alu_cout = alu_t[8];
      end
      default: ;
    endcase
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                       output logic [W-1:0] r, output logic c);
    logic [W:0] s;
    case (o)
      2'b00: begin r = x & y; c = 1'b0; end
      2'b01: begin r = x | y; c = 1'b0; end
      2'b10: begin s = {1'b0, x} + {1'b0, y}; r = s[W-1:0]; c = s[W]; end
      default: begin r = x - y; c = (x < y); end
    endcase
  endtask

  // Carry (ADD) or borrow (SUB) flowing into byte k, from the low k bytes alone.
  function automatic logic exp_cin(input logic [1:0] o, input logic [W-1:0] x,
                                   input logic [W-1:0] y, input int k);
    logic [63:0] m, xl, yl;
    m  = (64'd1 << (8 * k)) - 64'd1;
    xl = {32'd0, x} & m;
    yl = {32'd0, y} & m;
    if (o == 2'b10) return ((xl + yl) >> (8 * k)) != 64'd0;
    if (o == 2'b11) return xl < yl;
    return 1'b0;
  endfunction

  task automatic launch(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    start = 1'b1; op = o; a = x; b = y;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_done(output int l);
    l = -1;
    nbytes = 0;
    for (int n = 1; n <= BYTES + 6; n++) begin
      @(negedge clk);
      if (busy && nbytes < 8) begin
        cin_log[nbytes] = alu_cin;
        nbytes++;
      end
      if (done) begin
        l = n;
        break;
      end
    end
  endtask

  task automatic check_op(input string tag, input logic [1:0] o, input logic [W-1:0] x,
                          input logic [W-1:0] y, input int l);
    logic [W-1:0] r;
    logic c;
    model(o, x, y, r, c);
    check({tag, "_lat"}, 64'(l), 64'(BYTES + 1));
    check({tag, "_res"}, 64'(result), 64'(r));
    check({tag, "_carry"}, 64'(carry), 64'(c));
    check({tag, "_zero"}, 64'(zero), 64'(r == '0));
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_nbytes"}, 64'(nbytes), 64'(BYTES));
    for (int k = 0; k < BYTES && k < nbytes; k++)
      check($sformatf("%s_cin%0d", tag, k), 64'(cin_log[k]), 64'(exp_cin(o, x, y, k)));
  endtask

  task automatic do_op(input string tag, input logic [1:0] o, input logic [W-1:0] x,
                       input logic [W-1:0] y);
    int l;
    @(negedge clk);
    launch(o, x, y);
    wait_done(l);
    check_op(tag, o, x, y, l);
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 3))
      0: return '0;
      1: return '1;
      default: return W'($urandom);
    endcase
  endfunction

  initial begin
    int l;
    int ndone;
    logic [W-1:0] held;
    rst = 1'b1; start = 1'b0; op = 2'b00; a = '0; b = '0;
    #12;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_result", 64'(result), 64'd0);
    check("rst_carry", 64'(carry), 64'd0);
    check("rst_zero", 64'(zero), 64'd1);
    check("rst_alu", 64'({alu_a, alu_b, alu_cs, alu_cin}), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    do_op("add_wrap", 2'b10, 32'hFFFFFFFF, 32'h00000001);
    check("done_alu_idle", 64'({alu_a, alu_b, alu_cs, alu_cin}), 64'd0);
    do_op("sub_under", 2'b11, 32'h00000000, 32'h00000001);
    do_op("sub_eq", 2'b11, 32'h12345678, 32'h12345678);
    do_op("add_chain", 2'b10, 32'h00FF00FF, 32'h00010001);
    do_op("and", 2'b00, 32'hF0F0A5A5, 32'h0FF0FFFF);
    do_op("or", 2'b01, 32'hF0F0A5A5, 32'h0FF0FFFF);

    // Start pulsed mid-RUN must be ignored.
    @(negedge clk);
    launch(2'b10, 32'h01020304, 32'h10203040);
    @(negedge clk);
    start = 1'b1; op = 2'b00; a = 32'hDEADBEEF; b = 32'h0;
    @(posedge clk);
    #1 start = 1'b0;
    ndone = 0;
    held = '0;
    for (int n = 0; n < 12; n++) begin
      @(negedge clk);
      if (done) begin
        ndone++;
        held = result;
      end
    end
    check("ignore_ndone", 64'(ndone), 64'd1);
    check("ignore_res", 64'(held), 64'h11223344);

    // Start accepted in the DONE cycle.
    @(negedge clk);
    launch(2'b10, 32'h5, 32'h6);
    wait_done(l);
    check_op("chain1", 2'b10, 32'h5, 32'h6, l);
    launch(2'b11, 32'h100, 32'h1);
    wait_done(l);
    check_op("chain2", 2'b11, 32'h100, 32'h1, l);

    // Reset during RUN byte 2.
    @(negedge clk);
    launch(2'b10, 32'h11111111, 32'h22222222);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_done", 64'(done), 64'd0);
    check("abort_result", 64'(result), 64'd0);
    check("abort_zero", 64'(zero), 64'd1);
    check("abort_alu", 64'({alu_a, alu_b, alu_cs, alu_cin}), 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    ndone = 0;
    for (int n = 0; n < 8; n++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    check("abort_ndone", 64'(ndone), 64'd0);
    do_op("post_abort", 2'b10, 32'd1, 32'd2);

    for (int i = 0; i < 40; i++)
      do_op($sformatf("rnd%0d", i), 2'($urandom_range(0, 3)), pick(), pick());

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
